// File: rtl/sd_cache_lock_arbiter.sv
// -----------------------------------------------------------------------------
// sd_cache_lock_arbiter
//
// Round-robin arbiter sitting in front of the SD cache lock manager. It picks
// one of N requesting clients, drives the manager's acquire/release strobes,
// follows the manager's lock/unlock confirmations and returns a one-hot grant
// to the owning client.
//
// Optional feature (compile-time macro SD_LOCK_TIMEOUT_EN):
//   hold-timeout watchdog. When defined, a client that keeps the lock for
//   HOLD_MAX cycles is forced into release and timeout_evt pulses once.
//   When undefined, no hold counter exists and timeout_evt is tied low.
//
// Parameters:
//   N         number of clients (2..8)
//   HOLD_MAX  maximum hold time in cycles (watchdog build only)
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   req[N]        level request per client
//   rel[N]        release pulse per client, honoured from the owner only
//   gnt[N]        one-hot owner vector, zero when there is no owner
//   lock_acquire  acquire strobe to the lock manager (high in ACQ)
//   lock_release  release strobe to the lock manager (high in REL)
//   lock          manager confirms the acquire
//   unlock        manager confirms the release
//   busy          high whenever the arbiter is not IDLE
//   timeout_evt   one-cycle pulse when the watchdog forces a release
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate pending requests
// ACQ   | candidate registered, lock_acquire high, waiting for lock
// HELD  | candidate owns the lock, gnt asserted, waiting for owner rel
// REL   | lock_release high, gnt still asserted, waiting for unlock
// -----------------------------------------------------------------------------
module sd_cache_lock_arbiter #(
   parameter int N        = 4,
   parameter int HOLD_MAX = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] rel,
   output logic [N-1:0] gnt,
   output logic         lock_acquire,
   output logic         lock_release,
   input  logic         lock,
   input  logic         unlock,
   output logic         busy,
   output logic         timeout_evt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      HELD = 2'd2,
      REL  = 2'd3
   } state_t;

   if (N < 2 || N > 8 || HOLD_MAX < 2) begin : g_param_check
      $error("sd_cache_lock_arbiter: N must be 2..8 and HOLD_MAX at least 2");
   end

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q,   ptr_d;
   logic [PW-1:0]   cand_q,  cand_d;
   logic [N-1:0]    gnt_q,   gnt_d;

`ifdef SD_LOCK_TIMEOUT_EN
   localparam int            CW       = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_TC  = CW'(HOLD_MAX - 1);
   localparam logic [CW-1:0] HOLD_SAT = CW'(HOLD_MAX);

   logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
   logic            tmo_q,      tmo_d;
`endif

   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
      if (idx == PW'(N - 1)) return '0;
      else                   return idx + 1'b1;
   endfunction

   // First set request at or after the pointer, wrapping N-1 -> 0.
   function automatic logic [PW-1:0] rr_pick(input logic [N-1:0]  r,
                                             input logic [PW-1:0] p);
      logic [PW-1:0] idx;
      logic          found;
      idx     = p;
      found   = 1'b0;
      rr_pick = p;
      for (int i = 0; i < N; i++) begin
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
         idx = next_idx(idx);
      end
   endfunction

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cand_d  = cand_q;
      gnt_d   = gnt_q;
`ifdef SD_LOCK_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
      tmo_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               cand_d  = rr_pick(req, ptr_q);
               state_d = ACQ;
            end
         end
         ACQ: begin
            // A confirmation wins over a same-cycle withdrawal: the manager
            // already holds the lock on this client's behalf.
            if (lock) begin
               state_d = HELD;
               gnt_d   = N'(1) << cand_q;
`ifdef SD_LOCK_TIMEOUT_EN
               hold_cnt_d = '0;
`endif
            end else if (!req[cand_q]) begin
               state_d = IDLE;
               ptr_d   = next_idx(cand_q);
            end
         end
         HELD: begin
`ifdef SD_LOCK_TIMEOUT_EN
            if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + 1'b1;
            // Owner release takes priority so a coincident expiry is silent.
            if (rel[cand_q]) begin
               state_d = REL;
            end else if (hold_cnt_q == HOLD_TC) begin
               state_d = REL;
               tmo_d   = 1'b1;
            end
`else
            if (rel[cand_q]) state_d = REL;
`endif
         end
         REL: begin
            if (unlock) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = next_idx(cand_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cand_q  <= '0;
         gnt_q   <= '0;
`ifdef SD_LOCK_TIMEOUT_EN
         hold_cnt_q <= '0;
         tmo_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cand_q  <= cand_d;
         gnt_q   <= gnt_d;
`ifdef SD_LOCK_TIMEOUT_EN
         hold_cnt_q <= hold_cnt_d;
         tmo_q      <= tmo_d;
`endif
      end
   end

   // Strobes decode straight from the state flop so reset clears them
   // asynchronously and they can never overlap.
   assign gnt          = gnt_q;
   assign lock_acquire = (state_q == ACQ);
   assign lock_release = (state_q == REL);
   assign busy         = (state_q != IDLE);

`ifdef SD_LOCK_TIMEOUT_EN
   assign timeout_evt = tmo_q;
`else
   assign timeout_evt = 1'b0;
`endif

endmodule

// File: doc/sd_cache_lock_arbiter.md
# sd_cache_lock_arbiter

Round-robin arbiter placed directly upstream of the SD cache lock manager. It collects lock requests from N cache clients, selects one owner, and drives the manager's `lock_acquire`/`lock_release` strobes. It tracks ownership from the manager's `lock`/`unlock` confirmations and returns a one-hot grant to the owning client. An optional hold-timeout watchdog forcibly releases a lock that a client holds for too long.

## Interface
Parameters:
- `N`, 4: number of requesting clients (2..8).
- `HOLD_MAX`, 1024: maximum cycles a client may hold the lock (used only with the timeout feature).

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  N  level request per client; held until granted or withdrawn.
- `rel`  in  N  single-cycle release pulse per client; honored only from the current owner.
- `gnt`  out  N  one-hot owner vector; all-zero when no owner.
- `lock_acquire`  out  1  acquire strobe to the lock manager.
- `lock_release`  out  1  release strobe to the lock manager.
- `lock`  in  1  manager confirmation that the acquire took effect.
- `unlock`  in  1  manager confirmation that the release took effect.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_evt`  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- States: IDLE, ACQ, HELD, REL, encoded in 2 bits.
- Reset: state IDLE; `gnt`=0; `lock_acquire`=0; `lock_release`=0; `busy`=0; `timeout_evt`=0; round-robin pointer=0; hold counter=0.
- IDLE: if `req`≠0, register the candidate and go to ACQ. The candidate is the first set bit at or after the pointer, searching upward and wrapping from N-1 to 0.
- ACQ: `lock_acquire`=1, driven combinationally from state.
  - `lock`=1 → HELD; `gnt`=one-hot(candidate); hold counter=0.
  - Candidate's `req` drops while `lock`=0 → IDLE without a grant; pointer=candidate+1 mod N.
  - Otherwise stay in ACQ. The manager may already be locked by another agent.
- HELD: `gnt` held stable; the hold counter increments each cycle and saturates at HOLD_MAX.
  - Owner `rel`=1 → REL.
  - `rel` from a non-owner is ignored.
  - `req` from other clients is ignored until the lock returns to IDLE.
- REL: `lock_release`=1.
  - `unlock`=1 → IDLE; `gnt`=0; pointer=owner+1 mod N.
  - Otherwise stay in REL.
- `lock` outside ACQ and `unlock` outside REL are ignored.
- `lock_acquire` and `lock_release` are never high in the same cycle.

## Timing
- Request to `lock_acquire`: 1 cycle (`req` sampled in IDLE; ACQ entered at the next edge).
- ACQ with `lock`=1 → `gnt` visible the next cycle.
- Owner `rel` → `lock_release` high the next cycle; `gnt` stays high through REL and clears one cycle after `unlock`.
- Minimum acquire-hold-release loop with a 1-cycle hold: 4 cycles from `req` to `gnt`=0.
- Back-to-back: a pending `req` is re-arbitrated in the IDLE cycle after REL, so there is one IDLE cycle between owners.
- Simultaneous owner `rel` and watchdog expiry in the same cycle: treated as a normal release and `timeout_evt` stays 0.
- `rst_n` low in any state returns all outputs to reset values immediately, without waiting for a clock. No `lock_release` is issued for a lock held at reset; the downstream manager resets its own status.

## Configuration
- Macro: `SD_LOCK_TIMEOUT_EN`.
- Defined:
  - When the hold counter reaches HOLD_MAX-1 in HELD, the next edge enters REL and pulses `timeout_evt` for 1 cycle.
  - REL then proceeds as a normal release; the owner's later `rel` is ignored.
- Undefined:
  - No hold counter is instantiated; HELD exits only on owner `rel`.
  - `timeout_evt` is tied to 0 and HOLD_MAX is unused.

## Test plan
- Single client: N=4, `req`=0001, `lock` returned in ACQ → `lock_acquire` 1 cycle later, `gnt`=0001; `rel` pulse → `lock_release`; `unlock` → `gnt`=0000 and pointer=1.
- Round-robin fairness: `req`=1111 held through 8 complete lock cycles → grant order 0,1,2,3,0,1,2,3.
- Manager busy: `lock`=0 for 20 cycles in ACQ, then 1 → `lock_acquire` stays high 21 cycles, then `gnt` asserts.
- Withdrawal: candidate 2 drops `req` while in ACQ with `lock`=0 → IDLE, no grant, next candidate searched from 3.
- Timeout (macro defined, HOLD_MAX=16): owner never releases → `timeout_evt` pulse 16 cycles after the grant, `lock_release`, then `gnt`=0 after `unlock`. With the macro undefined, `gnt` persists indefinitely.
- Reset mid-HELD: `rst_n` low with `gnt`=0100 → `gnt`=0, `busy`=0, and both strobes 0 asynchronously; after reset, a pending `req`=1000 is granted starting from pointer 0.
